// File: rtl/asm_loop_ctrl.sv
// ASM-chart sequencer with a loadable loop down-counter and a registered exit code.
// Optional abort input when ASM_LOOP_ABORT_EN is defined.
//
//  state | meaning
//  S0    | idle, wait for x (load) or y (skip)
//  S1    | load loop count from len
//  S2    | decide: F -> fast exit, else check
//  S3    | fast exit, exit_code 01
//  S4    | check: E -> early exit, else loop
//  S5    | early exit, exit_code 10
//  S6    | loop, count down to zero
//  S7    | loop done, exit_code 11
module asm_loop_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             x,
    input  logic             y,
    input  logic [CNT_W-1:0] len,
    input  logic             F,
    input  logic             E,
`ifdef ASM_LOOP_ABORT_EN
    input  logic             abort,
`endif
    output logic [2:0]       state,
    output logic [7:0]       dec_out,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       exit_code
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       exit_nxt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= S0;
            cnt       <= '0;
            exit_code <= 2'b00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            exit_code <= exit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        exit_nxt  = exit_code;
        case (state)
            S0: begin
                if (x) begin
                    state_nxt = S1;
                end else if (y) begin
                    state_nxt = S2;
                    cnt_nxt   = '0;
                end
            end
            S1: begin
                cnt_nxt   = len;
                state_nxt = S2;
            end
            S2: state_nxt = F ? S3 : S4;
            S3: begin
                state_nxt = S0;
                exit_nxt  = 2'b01;
            end
            S4: state_nxt = E ? S5 : S6;
            S5: begin
                state_nxt = S0;
                exit_nxt  = 2'b10;
            end
            S6: begin
                // Decrement only while nonzero so a full-scale len never wraps.
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = S7;
                end
            end
            S7: begin
                state_nxt = S0;
                exit_nxt  = 2'b11;
            end
            default: state_nxt = S0;
        endcase
`ifdef ASM_LOOP_ABORT_EN
        if (abort && (state != S0)) begin
            state_nxt = S0;
            cnt_nxt   = '0;
            exit_nxt  = 2'b00;
        end
`endif
    end

    always_comb begin
        dec_out = 8'(1) << state;
        busy    = (state != S0);
        done    = (state == S3) || (state == S5) || (state == S7);
    end

endmodule

// File: doc/asm_loop_ctrl.md
Name: asm_loop_ctrl

Overview:
- Parametrised successor to the 8-state ASM-chart controllers: same 3-bit state register with one-hot decoded output, plus a loadable down-counter that turns the former fixed one-cycle S6 into a data-dependent loop.
- Adds a registered exit code so the datapath can tell which ASM exit path was taken.
- Sits between a datapath and the control inputs x/y/F/E; drives the datapath through dec_out.

Parameters:
- CNT_W, 4, width of the loop length input and the internal loop counter (must be at least 1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_b  in  1  asynchronous active-low reset.
- x  in  1  start request; sampled only in S0; loads the loop count.
- y  in  1  skip request; sampled only in S0 when x=0; enters at S2 with the counter cleared.
- len  in  CNT_W  loop length; sampled in S1.
- F  in  1  fast-exit select; sampled only in S2.
- E  in  1  early-exit select; sampled only in S4.
- state  out  3  current state code (S0=0 … S7=7).
- dec_out  out  8  one-hot decode of state (dec_out[i]=1 iff state==i).
- cnt  out  CNT_W  current loop counter value.
- busy  out  1  high when state != S0.
- done  out  1  high in S3, S5 and S7 (last cycle before return to S0).
- exit_code  out  2  registered code of the last completed pass: 00 none, 01 via S3, 10 via S5, 11 via S7.

Behaviour:
- Reset (asynchronous, rst_b=0) sets: state=S0, cnt=0, exit_code=00.
- Outputs after reset: dec_out=8'h01, busy=0, done=0.
- state, cnt and exit_code are registers. dec_out, busy and done are combinational decodes of state (zero latency).
- S0 (idle):
  - x=1 → S1 (x has priority over y).
  - x=0, y=1 → S2, with cnt<=0.
  - Otherwise stay in S0; cnt holds.
- S1 (load): cnt<=len; → S2 unconditionally.
- S2 (decide): F=1 → S3; otherwise → S4.
- S3 (fast exit): → S0; exit_code<=01.
- S4 (check): E=1 → S5; otherwise → S6.
- S5 (early exit): → S0; exit_code<=10.
- S6 (loop):
  - cnt != 0 → cnt<=cnt-1 and stay in S6.
  - cnt == 0 → S7.
  - With a loaded len=N, S6 occupies exactly N+1 cycles. Via the y path, S6 occupies 1 cycle.
- S7 (done): → S0; exit_code<=11.
- exit_code changes only on the S3/S5/S7→S0 transition and holds otherwise, including through idle.
- Pass latency, counted from the first cycle of S1 through the cycle the FSM is back in S0:
  - S1,S2,S3 → 3 cycles.
  - S1,S2,S4,S5 → 4 cycles.
  - S1,S2,S4,S6×(N+1),S7 → N+5 cycles.
- Maximum len (2^CNT_W−1):
  - No wrap-around.
  - The counter only decrements while nonzero and never underflows.
- Input sampling:
  - x/y are ignored outside S0. F is ignored outside S2. E is ignored outside S4. len is ignored outside S1.
  - A held x or y re-triggers a new pass immediately from S0.
- Reset mid-operation: from any state, returns to S0 asynchronously, clearing cnt and exit_code.
- Unreachable codes: none; all 8 codes are used.

Optional Feature:
- Macro: ASM_LOOP_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 sampled in any state other than S0 forces next state S0, cnt<=0, exit_code<=00.
  - abort has priority over all other transitions and is ignored in S0.
  - done is not asserted by an abort.
- Undefined:
  - No abort port; behaviour exactly as above.

Test Plan:
- Reset then idle: rst_b=0 for 10 ns, then x=y=0 for 3 cycles → state=0, dec_out=8'h01, busy=0, cnt=0, exit_code=00 throughout.
- Full loop: x=1 pulse, len=3, F=E=0 → state sequence 1,2,4,6,6,6,6,7,0; cnt 3,2,1,0 during S6; done=1 only in S7; exit_code=11 afterwards.
- Skip path: x=0, y=1 one cycle, F=E=0 → sequence 2,4,6,7,0; S6 lasts one cycle with cnt=0; exit_code=11.
- Fast exit: y=1, F=1 → sequence 2,3,0; done=1 in S3; exit_code=01. Then E=1, F=0, y=1 → sequence 2,4,5,0; exit_code=10.
- Boundary: len=2^CNT_W−1 (15) via x → S6 lasts 16 cycles, cnt reaches 0 without wrap. Next pass with len=0 → S6 lasts 1 cycle.
- Reset mid-loop: rst_b=0 while in S6 with cnt=5 → immediately state=0, cnt=0, exit_code=00. With ASM_LOOP_ABORT_EN, abort=1 in S6 → next cycle state=0, cnt=0, exit_code=00, done never asserted.
